// File: rtl/gm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gm_pkg
// Description : Shared defaults, FSM state encoding and tile code constants
//               for the graphics-memory refresh path.
// Revision    : 1.0 - initial release
// ============================================================================
package gm_pkg;

    localparam int GM_CELLS = 256;   // board cells copied per refresh
    localparam int GM_AW    = 8;     // board RAM / graphics memory address width
    localparam int GM_DW    = 4;     // tile code width
    localparam int GM_CW    = 4;     // cursor coordinate width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gm_state_t;

    // Tile codes as stored in board RAM: bit 3 marks a revealed cell,
    // 9..15 are revealed numbers.
    localparam logic [3:0] TILE_BLANK        = 4'h0;
    localparam logic [3:0] TILE_FLAG         = 4'h1;
    localparam int         TILE_REVEALED_BIT = 3;

endpackage : gm_pkg
`default_nettype wire

// File: rtl/gm_req_edge.sv
`default_nettype none
// ============================================================================
// Module      : gm_req_edge
// Description : Registers the retrace request once and produces one-cycle
//               rise/fall pulses. Source is in the same clock domain, so no
//               further synchronisation is applied.
// Revision    : 1.0 - initial release
// ============================================================================
module gm_req_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    output logic o_req_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_req_q;
    logic r_req_q2;

    // Two-stage history of the request level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q  <= 1'b0;
            r_req_q2 <= 1'b0;
        end else begin
            r_req_q  <= i_req;
            r_req_q2 <= r_req_q;
        end
    end

    assign o_req_q = r_req_q;
    assign o_rise  = r_req_q & ~r_req_q2;
    assign o_fall  = ~r_req_q & r_req_q2;

endmodule : gm_req_edge
`default_nettype wire

// File: rtl/gm_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gm_refresh_scheduler
// Description : Copies the 16x16 board RAM into graphics memory during
//               vertical retrace and snapshots the cursor together with each
//               completed copy so board and cursor never tear mid-frame.
//               Optional macro GM_FORCE_REFRESH_EN: copy on every retrace
//               regardless of the dirty flag (board_dirty ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module gm_refresh_scheduler
    import gm_pkg::*;
#(
    parameter int CELLS = GM_CELLS,
    parameter int AW    = GM_AW,
    parameter int DW    = GM_DW,
    parameter int CW    = GM_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          request,
    input  logic          board_dirty,
    output logic [AW-1:0] board_addr,
    input  logic [DW-1:0] board_data,
    input  logic [CW-1:0] current_x,
    input  logic [CW-1:0] current_y,
    output logic [AW-1:0] GMaddress,
    output logic [DW-1:0] GMdata,
    output logic          gm_we,
    output logic [CW-1:0] cur_x_q,
    output logic [CW-1:0] cur_y_q,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] c_LAST = AW'(CELLS - 1);

    gm_state_t     r_state;
    gm_state_t     w_state_next;

    logic          w_req_q;
    logic          w_req_rise;
    logic          w_unused_fall;
    logic          w_copy_needed;
    logic          w_start;
    logic          w_finish;
    logic          w_abort;
    logic          w_issue;

    logic [AW-1:0] r_rd_ptr;
    logic          r_wr_valid;
    logic [AW-1:0] r_wr_addr;
    logic          r_gm_we;
    logic [AW-1:0] r_gm_addr;
    logic [DW-1:0] r_gm_data;
    logic [CW-1:0] r_cur_x;
    logic [CW-1:0] r_cur_y;
    logic          r_busy;
    logic          r_done;

    gm_req_edge u_req_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (request),
        .o_req_q (w_req_q),
        .o_rise  (w_req_rise),
        .o_fall  (w_unused_fall)
    );

`ifdef GM_FORCE_REFRESH_EN
    logic w_unused_dirty;

    assign w_unused_dirty = board_dirty;
    assign w_copy_needed  = 1'b1;
`else
    logic r_dirty;

    // Dirty flag: a change during FILL entry wins over the clear, and an
    // aborted copy leaves the board marked stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dirty <= 1'b1;
        end else if (board_dirty || w_abort) begin
            r_dirty <= 1'b1;
        end else if (w_start) begin
            r_dirty <= 1'b0;
        end
    end

    assign w_copy_needed = r_dirty;
`endif

    // Reads are issued only while in FILL with the retrace window still open.
    assign w_issue = (r_state == FILL) && request;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and single-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_rise && w_copy_needed) begin
                    w_state_next = FILL;
                    w_start      = 1'b1;
                end
            end
            FILL: begin
                if (!request) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end else if (r_rd_ptr == c_LAST) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!request) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_finish     = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Read pointer, write pipeline, status flags and cursor snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_gm_we    <= 1'b0;
            r_gm_addr  <= '0;
            r_gm_data  <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Pointer parks at zero outside FILL and after the last cell,
            // so it never wraps past CELLS-1.
            if (w_issue && (r_rd_ptr != c_LAST)) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= '0;
            end

            // Stage 1 follows the board RAM read latency.
            r_wr_valid <= w_issue;
            r_wr_addr  <= r_rd_ptr;

            // Stage 2 drives graphics memory; gating with the live request
            // squashes the in-flight write as soon as the window closes.
            r_gm_we <= r_wr_valid && request;
            if (r_wr_valid) begin
                r_gm_addr <= r_wr_addr;
                r_gm_data <= board_data;
            end

            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_finish || w_abort) begin
                r_busy <= 1'b0;
            end

            r_done <= w_finish;

            if (w_finish) begin
                r_cur_x <= current_x;
                r_cur_y <= current_y;
            end
        end
    end

    assign board_addr = r_rd_ptr;
    assign GMaddress  = r_gm_addr;
    assign GMdata     = r_gm_data;
    assign gm_we      = r_gm_we;
    assign cur_x_q    = r_cur_x;
    assign cur_y_q    = r_cur_y;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule : gm_refresh_scheduler
`default_nettype wire

// File: tb/tb_gm_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gm_refresh_scheduler
// Description : Directed self-checking bench for gm_refresh_scheduler with a
//               synchronous board RAM model and a graphics memory monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gm_refresh_scheduler;

    logic       clk;
    logic       rst_n;
    logic       request;
    logic       board_dirty;
    logic [7:0] board_addr;
    logic [3:0] board_data;
    logic [3:0] current_x;
    logic [3:0] current_y;
    logic [7:0] GMaddress;
    logic [3:0] GMdata;
    logic       gm_we;
    logic [3:0] cur_x_q;
    logic [3:0] cur_y_q;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Monitor state
    logic [3:0] bram   [256];
    logic [3:0] gm_mem [256];
    int         total_we     = 0;
    int         run          = 0;
    int         last_run     = 0;
    int         addr_err     = 0;
    int         stray_we     = 0;
    int         done_cnt     = 0;
    int         done_cyc     = 0;
    int         first_we_cyc = 0;
    logic       prev_we      = 1'b0;
    logic [7:0] prev_addr    = 8'h00;

    gm_refresh_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .board_dirty (board_dirty),
        .board_addr  (board_addr),
        .board_data  (board_data),
        .current_x   (current_x),
        .current_y   (current_y),
        .GMaddress   (GMaddress),
        .GMdata      (GMdata),
        .gm_we       (gm_we),
        .cur_x_q     (cur_x_q),
        .cur_y_q     (cur_y_q),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges; read only away from the edge.
    always @(posedge clk) cyc++;

    // Board RAM: contents addr[3:0]^8, one-cycle synchronous read.
    initial begin
        for (int i = 0; i < 256; i++) begin
            bram[i] = 4'(i) ^ 4'h8;
            gm_mem[i] = 4'h0;
        end
    end
    always @(posedge clk) board_data <= bram[board_addr];

    // Graphics memory side: record writes, burst lengths, ordering, done.
    always @(negedge clk) begin
        if (gm_we) begin
            if (!prev_we) begin
                run = 0;
                first_we_cyc = cyc;
                if (GMaddress != 8'h00) addr_err++;
            end else if (GMaddress != 8'(prev_addr + 8'h01)) begin
                addr_err++;
            end
            run++;
            total_we++;
            gm_mem[GMaddress] = GMdata;
            if (!busy) stray_we++;
        end else if (prev_we) begin
            last_run = run;
        end
        prev_we   = gm_we;
        prev_addr = GMaddress;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_dirty();
        board_dirty = 1'b1;
        tick(1);
        board_dirty = 1'b0;
        tick(2);
    endtask

    // One retrace window of 300 cycles; a copy must be complete within it.
    task automatic run_retrace(input string tag, input bit exp_copy);
        int b_we;
        int b_done;
        int t0;
        b_we    = total_we;
        b_done  = done_cnt;
        request = 1'b1;
        t0      = cyc;
        tick(300);
        chk({tag, "_writes"}, 32'(total_we - b_we), exp_copy ? 32'd256 : 32'd0);
        chk({tag, "_done"}, 32'(done_cnt - b_done), exp_copy ? 32'd1 : 32'd0);
        if (exp_copy) begin
            chk({tag, "_done_lat"}, 32'(done_cyc - t0), 32'd260);
            chk({tag, "_first_we"}, 32'(first_we_cyc - t0), 32'd4);
            chk({tag, "_burst"}, 32'(last_run), 32'd256);
        end
        request = 1'b0;
        tick(4);
    endtask

    initial begin
        int  b_we;
        int  b_done;
        bit  reached;

        rst_n       = 1'b0;
        request     = 1'b0;
        board_dirty = 1'b0;
        current_x   = 4'd5;
        current_y   = 4'd9;
        tick(3);

        // Reset state
        chk("rst_gm_we", 32'(gm_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_board_addr", 32'(board_addr), 32'd0);
        chk("rst_gmaddr", 32'(GMaddress), 32'd0);
        chk("rst_gmdata", 32'(GMdata), 32'd0);
        chk("rst_cur", 32'({cur_x_q, cur_y_q}), 32'h00);

        rst_n = 1'b1;
        tick(3);

        // First retrace copies because dirty starts set
        run_retrace("copy1", 1'b1);
        chk("gm_2A", 32'(gm_mem[8'h2A]), 32'h2);
        chk("gm_FF", 32'(gm_mem[8'hFF]), 32'h7);
        chk("gm_00", 32'(gm_mem[8'h00]), 32'h8);
        chk("copy1_cur", 32'({cur_x_q, cur_y_q}), 32'h59);
        chk("copy1_busy", 32'(busy), 32'd0);

        // Clean board: no copy unless forced
`ifdef GM_FORCE_REFRESH_EN
        run_retrace("clean", 1'b1);
`else
        run_retrace("clean", 1'b0);
`endif

        // Cursor moves mid-copy: snapshot only at completion
        pulse_dirty();
        b_done  = done_cnt;
        request = 1'b1;
        tick(100);
        current_x = 4'd6;
        tick(50);
        chk("midcopy_cur", 32'({cur_x_q, cur_y_q}), 32'h59);
        for (int i = 0; i < 200; i++) begin
            if (done_cnt != b_done) break;
            tick(1);
        end
        chk("cursor_done", 32'(done_cnt - b_done), 32'd1);
        chk("cursor_new", 32'({cur_x_q, cur_y_q}), 32'h69);
        request = 1'b0;
        tick(4);

        // Abort: request drops ~100 cycles into FILL
        pulse_dirty();
        current_x = 4'd3;
        b_done    = done_cnt;
        request   = 1'b1;
        tick(102);
        request = 1'b0;
        tick(1);
        chk("abort_we", 32'(gm_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        tick(300);
        chk("abort_done", 32'(done_cnt - b_done), 32'd0);
        chk("abort_burst", 32'(last_run), 32'd99);
        chk("abort_cur", 32'({cur_x_q, cur_y_q}), 32'h69);
        run_retrace("postAbort", 1'b1);
        chk("postAbort_cur", 32'({cur_x_q, cur_y_q}), 32'h39);

        // board_dirty coincides with FILL entry
        pulse_dirty();
        b_we    = total_we;
        b_done  = done_cnt;
        request = 1'b1;
        tick(1);
        board_dirty = 1'b1;
        tick(1);
        board_dirty = 1'b0;
        tick(298);
        chk("race_writes", 32'(total_we - b_we), 32'd256);
        chk("race_done", 32'(done_cnt - b_done), 32'd1);
        request = 1'b0;
        tick(4);
        run_retrace("raceAgain", 1'b1);

        // Asynchronous reset at write 128
        pulse_dirty();
        request = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (gm_we && run >= 128) begin
                reached = 1'b1;
                break;
            end
        end
        chk("rst_reach128", 32'(reached), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_gm_we", 32'(gm_we), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_board_addr", 32'(board_addr), 32'd0);
        chk("arst_gmaddr", 32'(GMaddress), 32'd0);
        chk("arst_gmdata", 32'(GMdata), 32'd0);
        chk("arst_cur", 32'({cur_x_q, cur_y_q}), 32'h00);
        tick(2);
        request = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        run_retrace("postReset", 1'b1);
        chk("postReset_cur", 32'({cur_x_q, cur_y_q}), 32'h39);

        // Global write-stream properties
        chk("addr_order", 32'(addr_err), 32'd0);
        chk("we_outside_busy", 32'(stray_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gm_refresh_scheduler
`default_nettype wire
